// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : io_bus_master
// Brief   : IN/OUT transfer master for an 8-bit IO port bus. Define
//           IO_BUS_POLL_EN to poll UART status before UART data transfers.
// Revision: 1.0
// ============================================================================
module io_bus_master #(
    parameter logic [7:0]  UART_DATA_PORT = 8'h01,
    parameter logic [7:0]  RX_STATUS_PORT = 8'h02,
    parameter logic [7:0]  TX_STATUS_PORT = 8'h03,
    parameter logic [15:0] POLL_LIMIT     = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [7:0] req_port,
    input  logic [7:0] req_wdata,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic [7:0] IO_port_ID,
    output logic [7:0] IO_write_data,
    output logic       IO_write_strobe,
    output logic       IO_read_strobe,
    input  logic [7:0] IO_read_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POLL     = 3'd1,
        POLL_GAP = 3'd2,
        XFER     = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic       r_write;
    logic [7:0] r_port;
    logic [7:0] r_wdata;

    logic       w_accept;
    logic       w_write;
    logic [7:0] w_port;
    logic [7:0] w_wdata;
    logic [7:0] w_rdata_next;
    logic [7:0] w_port_id_next;
    logic [7:0] w_bus_wdata_next;
    logic       w_wstb_next;
    logic       w_rstb_next;

`ifdef IO_BUS_POLL_EN
    logic [15:0] r_poll_cnt;
    logic [15:0] w_poll_cnt_next;
    logic        w_timeout_next;
`else
    logic        w_unused_cfg;
    assign w_unused_cfg = ^{UART_DATA_PORT, RX_STATUS_PORT, TX_STATUS_PORT, POLL_LIMIT};
    assign rsp_timeout  = 1'b0;
`endif

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_ready && req_valid;

    // Bus outputs are registered, so they are decoded from the next state and
    // must see the request fields on the accepting edge before they are latched.
    assign w_write = w_accept ? req_write : r_write;
    assign w_port  = w_accept ? req_port  : r_port;
    assign w_wdata = w_accept ? req_wdata : r_wdata;

    always_comb begin
        w_state_next = r_state;
        w_rdata_next = rsp_rdata;
`ifdef IO_BUS_POLL_EN
        w_poll_cnt_next = r_poll_cnt;
        w_timeout_next  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef IO_BUS_POLL_EN
                    w_poll_cnt_next = 16'd0;
                    w_state_next    = (req_port == UART_DATA_PORT) ? POLL : XFER;
`else
                    w_state_next    = XFER;
`endif
                end
            end
`ifdef IO_BUS_POLL_EN
            POLL: begin
                // TX wants "buffer full" clear; RX wants "data present" set.
                if (r_write ? !IO_read_data[0] : IO_read_data[0]) begin
                    w_state_next = XFER;
                end else begin
                    w_poll_cnt_next = r_poll_cnt + 16'd1;
                    if ((r_poll_cnt + 16'd1) == POLL_LIMIT) begin
                        w_state_next   = RESP;
                        w_timeout_next = 1'b1;
                        w_rdata_next   = 8'h00;
                    end else begin
                        w_state_next   = POLL_GAP;
                    end
                end
            end
            POLL_GAP: w_state_next = POLL;
`endif
            XFER: begin
                w_state_next = RESP;
                w_rdata_next = r_write ? 8'h00 : IO_read_data;
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        w_port_id_next   = 8'h00;
        w_bus_wdata_next = 8'h00;
        w_wstb_next      = 1'b0;
        w_rstb_next      = 1'b0;
        case (w_state_next)
            XFER: begin
                w_port_id_next = w_port;
                if (w_write) begin
                    w_wstb_next      = 1'b1;
                    w_bus_wdata_next = w_wdata;
                end else begin
                    w_rstb_next      = 1'b1;
                end
            end
`ifdef IO_BUS_POLL_EN
            POLL: begin
                w_rstb_next    = 1'b1;
                w_port_id_next = w_write ? TX_STATUS_PORT : RX_STATUS_PORT;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_write         <= 1'b0;
            r_port          <= 8'h00;
            r_wdata         <= 8'h00;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= 8'h00;
            IO_port_ID      <= 8'h00;
            IO_write_data   <= 8'h00;
            IO_write_strobe <= 1'b0;
            IO_read_strobe  <= 1'b0;
`ifdef IO_BUS_POLL_EN
            r_poll_cnt      <= 16'd0;
            rsp_timeout     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write <= req_write;
                r_port  <= req_port;
                r_wdata <= req_wdata;
            end
            rsp_valid       <= (w_state_next == RESP);
            rsp_rdata       <= w_rdata_next;
            IO_port_ID      <= w_port_id_next;
            IO_write_data   <= w_bus_wdata_next;
            IO_write_strobe <= w_wstb_next;
            IO_read_strobe  <= w_rstb_next;
`ifdef IO_BUS_POLL_EN
            r_poll_cnt      <= w_poll_cnt_next;
            rsp_timeout     <= w_timeout_next;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_io_bus_master
// Brief   : Scoreboard bench for io_bus_master; poll cases need IO_BUS_POLL_EN.
// Revision: 1.0
// ============================================================================
module tb_io_bus_master;

    localparam logic [7:0] UDP = 8'h01;
    localparam logic [7:0] RXS = 8'h02;
    localparam logic [7:0] TXS = 8'h03;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_write;
    logic [7:0] req_port, req_wdata;
    logic       req_ready, rsp_valid, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic [7:0] IO_port_ID, IO_write_data;
    logic       IO_write_strobe, IO_read_strobe;
    logic [7:0] IO_read_data;

    io_bus_master #(
        .UART_DATA_PORT (UDP),
        .RX_STATUS_PORT (RXS),
        .TX_STATUS_PORT (TXS),
        .POLL_LIMIT     (16'd4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_port        (req_port),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_timeout     (rsp_timeout),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       to;
        int         cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    // Bus peripheral model
    logic [7:0] uart_data = 8'h00;
    logic [7:0] data_val  = 8'h00;
    logic       tx_full   = 1'b0;
    int         rx_after  = 0;
    int         rx_total  = 0;
    int         rx_base   = 0;

    always_comb begin
        IO_read_data = data_val;
        if (IO_port_ID == RXS)      IO_read_data = {7'd0, (rx_total - rx_base) >= rx_after};
        else if (IO_port_ID == TXS) IO_read_data = {7'd0, tx_full};
        else if (IO_port_ID == UDP) IO_read_data = uart_data;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (IO_read_strobe && IO_port_ID == RXS) rx_total = rx_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int  wr_total = 0, st_total = 0, rdd_total = 0;
    logic prev_wr = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("strobe_excl", {31'd0, IO_write_strobe & IO_read_strobe}, 32'd0);
            if (IO_write_strobe) begin
                wr_total++;
                if (prev_wr) begin
                    total++; bad++;
                    $display("FAIL wr_strobe_len: got 2+ cycles expected 1");
                end
            end
            if (IO_read_strobe) begin
                if (IO_port_ID == RXS || IO_port_ID == TXS) st_total++;
                else rdd_total++;
            end
            prev_wr = IO_write_strobe;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid rdata=%0h expected none", rsp_rdata);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
                    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_port"},  {24'd0, IO_port_ID}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, IO_write_data}, 32'd0);
        chk({tag, "_stb"},   {30'd0, IO_write_strobe, IO_read_strobe}, 32'd0);
    endtask

    // lat: cycles from the accept cycle to the rsp_valid cycle
    task automatic do_req(input logic wr, input logic [7:0] port, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input logic exp_to, input int lat);
        int n;
        int acc;
        n = 0;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_port = port; req_wdata = wd;
        @(posedge clk); #1;
        acc = cyc;
        sb.push_back('{exp_rd, exp_to, acc + lat});
        // Keep garbage on the request lines while busy; it must be ignored.
        req_port = 8'hEE; req_wdata = 8'h77; req_write = ~wr;
        chk("busy_ready", {31'd0, req_ready}, 32'd0);
        if (lat == 1) begin
            chk("xfer_wstb", {31'd0, IO_write_strobe}, {31'd0, wr});
            chk("xfer_rstb", {31'd0, IO_read_strobe}, {31'd0, ~wr});
            chk("xfer_port", {24'd0, IO_port_ID}, {24'd0, port});
            if (wr) chk("xfer_wdata", {24'd0, IO_write_data}, {24'd0, wd});
            @(posedge clk); #1;
            chk_idle_bus("resp_bus");
            @(posedge clk); #1;
            req_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            n = 0;
            while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
            chk("rsp_wait_left", sb.size(), 32'd0);
        end
    endtask

    int st0, rd0, wr0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_port = 8'h00; req_wdata = 8'h00;
        #1;
        chk_idle_bus("reset");
        chk("reset_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
        chk("reset_rdata", {24'd0, rsp_rdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_ready", {31'd0, req_ready}, 32'd1);

        do_req(1'b1, 8'h05, 8'hA5, 8'h00, 1'b0, 1);
        rx_base = rx_total; rx_after = 0;
        do_req(1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 1);
        data_val = 8'hC3;
        do_req(1'b0, 8'h40, 8'h00, 8'hC3, 1'b0, 1);
        do_req(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1);
        data_val = 8'h5E;
        do_req(1'b0, 8'h00, 8'h00, 8'h5E, 1'b0, 1);
        do_req(1'b1, 8'h7F, 8'h00, 8'h00, 1'b0, 1);

`ifdef IO_BUS_POLL_EN
        rx_base = rx_total; rx_after = 3; uart_data = 8'h3C;
        st0 = st_total; rd0 = rdd_total; wr0 = wr_total;
        do_req(1'b0, UDP, 8'h00, 8'h3C, 1'b0, 8);
        chk("pollrd_status_stb", st_total - st0, 32'd4);
        chk("pollrd_data_stb", rdd_total - rd0, 32'd1);
        chk("pollrd_wr_stb", wr_total - wr0, 32'd0);

        tx_full = 1'b1;
        st0 = st_total; rd0 = rdd_total; wr0 = wr_total;
        do_req(1'b1, UDP, 8'h55, 8'h00, 1'b1, 7);
        chk("timeout_status_stb", st_total - st0, 32'd4);
        chk("timeout_data_stb", rdd_total - rd0, 32'd0);
        chk("timeout_wr_stb", wr_total - wr0, 32'd0);

        req_valid = 1'b1; req_write = 1'b1; req_port = UDP; req_wdata = 8'h99;
`else
        req_valid = 1'b1; req_write = 1'b1; req_port = 8'h05; req_wdata = 8'h99;
`endif
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_reset_stb", {31'd0, IO_read_strobe | IO_write_strobe}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_idle_bus("async_reset");
        chk("async_reset_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
        chk("async_reset_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; tx_full = 1'b0;
        do_req(1'b1, 8'h05, 8'h5A, 8'h00, 1'b0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
